// File: rtl/dpll_defs.sv
// ---------------------------------------------------------------------------------------------
// dpll_defs: shared constants and types for the DPLL blocks (loop filter, ID counter, divider).
//   DivNDef    - default output divider ratio
//   PendWDef   - default width of the signed pending-correction accumulator
//   LockWinDef - default quiet-pulse window before lock asserts
//   pend_max() - largest magnitude the pending accumulator holds for a given width
//   ph_e       - two-phase slot sequencer state (even = insertion slot, odd = nominal slot)
//   slot_e     - decision taken for the current slot
// ---------------------------------------------------------------------------------------------
package dpll_defs;

   localparam int unsigned DivNDef    = 16;
   localparam int unsigned PendWDef   = 4;
   localparam int unsigned LockWinDef = 64;

   // Symmetric range: the most negative two's-complement code is never used.
   function automatic int pend_max(input int unsigned width);
      return (1 << (width - 1)) - 1;
   endfunction

   typedef enum logic {
      PhEven = 1'b0,
      PhOdd  = 1'b1
   } ph_e;

   typedef enum logic [1:0] {
      SlotIdle,
      SlotNominal,
      SlotDelete,
      SlotInsert
   } slot_e;

endpackage

// File: rtl/freq_divider.sv
// ---------------------------------------------------------------------------------------------
// freq_divider: turns a stream of 1-cycle pulses into a square wave of 1/DIV_N the pulse rate.
//   clk     in   system clock
//   reset   in   synchronous, active-high reset
//   en_i    in   clock enable; low holds count and output
//   pulse_i in   input pulse (counted when en_i is high)
//   sq_o    out  registered square wave, toggles every DIV_N/2 counted pulses
// DIV_N must be even and >= 2.
// ---------------------------------------------------------------------------------------------
module freq_divider #(
   parameter int unsigned DIV_N = 16
) (
   input  logic clk,
   input  logic reset,
   input  logic en_i,
   input  logic pulse_i,
   output logic sq_o
);

   localparam int unsigned CntW = (DIV_N > 2) ? $clog2(DIV_N) : 1;
   localparam logic [CntW-1:0] CntHalf = CntW'(DIV_N / 2 - 1);
   localparam logic [CntW-1:0] CntLast = CntW'(DIV_N - 1);

   logic [CntW-1:0] cnt_q, cnt_d;
   logic            sq_q, sq_d;

   always_comb begin
      cnt_d = cnt_q;
      sq_d  = sq_q;
      if (en_i && pulse_i) begin
         cnt_d = (cnt_q == CntLast) ? '0 : cnt_q + 1'b1;
         // Toggling at the half and last count gives a 50% duty cycle.
         if (cnt_q == CntHalf || cnt_q == CntLast) begin
            sq_d = ~sq_q;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_q <= '0;
         sq_q  <= 1'b0;
      end else begin
         cnt_q <= cnt_d;
         sq_q  <= sq_d;
      end
   end

   assign sq_o = sq_q;

endmodule

// File: rtl/id_counter.sv
// ---------------------------------------------------------------------------------------------
// id_counter: increment/decrement counter stage of the DCO, downstream of the DLF loop filter.
// Nominally emits one idOut pulse every 2 cycles (in the odd slot). A DLF carry fills the next
// even slot with an extra pulse; a DLF borrow empties the next odd slot. Requests are queued in a
// saturating signed accumulator (pend) and drained at most one per 2 cycles.
//   clk     in   system clock
//   reset   in   synchronous, active-high reset (discards pending corrections)
//   enable  in   clock enable; low freezes state, forces idOut low, drops carry/borrow
//   carry   in   1-cycle increment request
//   borrow  in   1-cycle decrement request
//   idOut   out  registered 1-cycle pulse
//   fOut    out  registered square wave, idOut divided by DIV_N
//   pend    out  signed pending-correction count (debug)
//   locked  out  lock indicator; tied low unless IDC_LOCK_DETECT_EN is defined
// Build option: define IDC_LOCK_DETECT_EN to enable the quiet-pulse lock detector.
// ---------------------------------------------------------------------------------------------
module id_counter
   import dpll_defs::*;
#(
   parameter int unsigned DIV_N    = DivNDef,
   parameter int unsigned PEND_W   = PendWDef,
   parameter int unsigned LOCK_WIN = LockWinDef
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     enable,
   input  logic                     carry,
   input  logic                     borrow,
   output logic                     idOut,
   output logic                     fOut,
   output logic signed [PEND_W-1:0] pend,
   output logic                     locked
);

   // Two guard bits cover pend +/- 2 requests without wrap before saturation.
   localparam int unsigned SumW = PEND_W + 2;
   localparam logic signed [SumW-1:0] PendMaxS = SumW'(pend_max(PEND_W));
   localparam logic signed [SumW-1:0] PendMinS = -PendMaxS;
   localparam logic signed [SumW-1:0] One      = SumW'(1);

   if (DIV_N < 2 || (DIV_N % 2) != 0 || PEND_W < 2 || LOCK_WIN < 1) begin : g_param_check
      $error("id_counter: DIV_N must be even >= 2, PEND_W >= 2, LOCK_WIN >= 1");
   end

   ph_e                     ph_q;
   logic signed [PEND_W-1:0] pend_q, pend_d;
   logic                    id_q;
   slot_e                   slot;
   logic signed [SumW-1:0]  pend_ext, sum;

   // Slot decision always uses the registered backlog, before this cycle's requests.
   always_comb begin
      slot = SlotIdle;
      if (ph_q == PhOdd) begin
         slot = pend_q[PEND_W-1] ? SlotDelete : SlotNominal;
      end else if (!pend_q[PEND_W-1] && (pend_q != '0)) begin
         slot = SlotInsert;
      end
   end

   assign pend_ext = {{2{pend_q[PEND_W-1]}}, pend_q};

   always_comb begin
      sum = pend_ext;
      if (carry) begin
         sum = sum + One;
      end
      if (borrow) begin
         sum = sum - One;
      end
      // A deleted pulse repays one unit of negative backlog; an inserted one spends a positive.
      if (slot == SlotDelete) begin
         sum = sum + One;
      end
      if (slot == SlotInsert) begin
         sum = sum - One;
      end
      if (sum > PendMaxS) begin
         pend_d = PendMaxS[PEND_W-1:0];
      end else if (sum < PendMinS) begin
         pend_d = PendMinS[PEND_W-1:0];
      end else begin
         pend_d = sum[PEND_W-1:0];
      end
   end

   // Slot sequencer and correction accumulator; idOut is registered here.
   always_ff @(posedge clk) begin
      if (reset) begin
         ph_q   <= PhEven;
         pend_q <= '0;
         id_q   <= 1'b0;
      end else if (enable) begin
         ph_q   <= (ph_q == PhEven) ? PhOdd : PhEven;
         pend_q <= pend_d;
         id_q   <= (slot == SlotNominal) || (slot == SlotInsert);
      end else begin
         id_q   <= 1'b0;
      end
   end

   freq_divider #(
      .DIV_N (DIV_N)
   ) u_div (
      .clk     (clk),
      .reset   (reset),
      .en_i    (enable),
      .pulse_i (id_q),
      .sq_o    (fOut)
   );

   assign idOut = id_q;
   assign pend  = pend_q;

`ifdef IDC_LOCK_DETECT_EN
   localparam int unsigned QuietW = $clog2(LOCK_WIN + 1);
   localparam logic [QuietW-1:0] QuietMax = QuietW'(LOCK_WIN);

   logic [QuietW-1:0] quiet_q, quiet_d;
   logic              locked_q, locked_d;

   always_comb begin
      quiet_d  = quiet_q;
      locked_d = locked_q;
      if (slot == SlotDelete || slot == SlotInsert) begin
         quiet_d  = '0;
         locked_d = 1'b0;
      end else if (slot == SlotNominal) begin
         if (quiet_q != QuietMax) begin
            quiet_d = quiet_q + 1'b1;
         end
         if (quiet_d == QuietMax) begin
            locked_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         quiet_q  <= '0;
         locked_q <= 1'b0;
      end else if (enable) begin
         quiet_q  <= quiet_d;
         locked_q <= locked_d;
      end
   end

   assign locked = locked_q;
`else
   assign locked = 1'b0;
`endif

endmodule

// File: tb/tb_id_counter.sv
// ---------------------------------------------------------------------------------------------
// tb_id_counter: self-checking bench for id_counter (DIV_N=16, PEND_W=4, LOCK_WIN=64).
// A behavioural model tracks the pulse slots, the backlog and the total pulse count; fOut is
// derived from the pulse count alone. Directed windows pin the model with literal pulse counts.
// ---------------------------------------------------------------------------------------------
module tb_id_counter;

   localparam int unsigned DivN    = 16;
   localparam int unsigned PendW   = 4;
   localparam int unsigned LockWin = 64;
   localparam int          PMax    = 7;
`ifdef IDC_LOCK_DETECT_EN
   localparam bit LockEn = 1'b1;
`else
   localparam bit LockEn = 1'b0;
`endif

   logic clk = 1'b0;
   logic reset, enable, carry, borrow;
   logic idOut, fOut, locked;
   logic signed [PendW-1:0] pend;

   int tests = 0;
   int fails = 0;
   int cyc   = 0;

   id_counter #(
      .DIV_N    (DivN),
      .PEND_W   (PendW),
      .LOCK_WIN (LockWin)
   ) dut (
      .clk    (clk),
      .reset  (reset),
      .enable (enable),
      .carry  (carry),
      .borrow (borrow),
      .idOut  (idOut),
      .fOut   (fOut),
      .pend   (pend),
      .locked (locked)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic signed [31:0] act, input int exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
      end
   endtask

   // ---------------- behavioural model ----------------
   bit m_valid = 1'b0;
   int m_slot_odd, m_pend, m_id, m_pulses, m_quiet, m_lock;
   int m_take, m_out;

   always @(posedge clk) begin
      cyc++;
      if (reset) begin
         m_valid = 1'b1;
         m_slot_odd = 0; m_pend = 0; m_id = 0; m_pulses = 0; m_quiet = 0; m_lock = 0;
      end else if (m_valid && enable) begin
         if (m_id != 0) m_pulses++;
         // Odd slots carry the nominal pulse unless a negative backlog eats it;
         // even slots are empty unless a positive backlog fills them.
         if (m_slot_odd != 0) begin
            m_out  = (m_pend >= 0) ? 1 : 0;
            m_take = (m_pend < 0) ? -1 : 0;
         end else begin
            m_out  = (m_pend > 0) ? 1 : 0;
            m_take = m_out;
         end
         m_pend = m_pend + int'(carry) - int'(borrow) - m_take;
         if (m_pend > PMax) m_pend = PMax;
         if (m_pend < -PMax) m_pend = -PMax;
         if (m_take != 0) begin
            m_quiet = 0;
            m_lock  = 0;
         end else if (m_out != 0) begin
            if (m_quiet < LockWin) m_quiet++;
            if (m_quiet >= LockWin) m_lock = 1;
         end
         m_id = m_out;
         m_slot_odd = 1 - m_slot_odd;
      end else if (m_valid) begin
         m_id = 0;
      end
   end

   // ---------------- compare process ----------------
   always @(negedge clk) begin
      if (m_valid) begin
         check("idOut", idOut, m_id);
         check("fOut", fOut, ((m_pulses % DivN) >= (DivN / 2)) ? 1 : 0);
         check("pend", pend, m_pend);
         check("locked", locked, LockEn ? m_lock : 0);
      end
   end

   // ---------------- directed helpers ----------------
   task automatic window(input int n, output int n_id, output int n_f);
      n_id = 0;
      n_f  = 0;
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         n_id += int'(idOut);
         n_f  += int'(fOut);
      end
   endtask

   task automatic wait_rise(output int at, output bit ok);
      logic prev;
      ok   = 1'b0;
      at   = 0;
      prev = fOut;
      for (int i = 0; i < 100 && !ok; i++) begin
         @(negedge clk);
         if (!prev && fOut) begin
            ok = 1'b1;
            at = cyc;
         end
         prev = fOut;
      end
   endtask

   task automatic pulse_req(input bit c, input bit b, input int n);
      carry  = c;
      borrow = b;
      repeat (n) @(negedge clk);
      carry  = 1'b0;
      borrow = 1'b0;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
      $fatal(1);
   end

   initial begin
      int  n_id, n_f, t0, t1, guard;
      bit  ok0, ok1;
      reset = 1'b1; enable = 1'b0; carry = 1'b0; borrow = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_idOut", idOut, 0);
      check("rst_fOut", fOut, 0);
      check("rst_pend", pend, 0);
      check("rst_locked", locked, 0);

      // Nominal rate and divider.
      reset = 1'b0; enable = 1'b1;
      repeat (64) @(negedge clk);
      window(32, n_id, n_f);
      check("nominal_pulses", n_id, 16);
      check("nominal_fout_high", n_f, 16);
      wait_rise(t0, ok0);
      wait_rise(t1, ok1);
      check("fout_rise_found", (ok0 && ok1) ? 1 : 0, 1);
      check("fout_period", t1 - t0, 32);

      // Single carry inserts one pulse.
      pulse_req(1'b1, 1'b0, 1);
      check("carry_pend", pend, 1);
      window(32, n_id, n_f);
      check("carry_pulses", n_id, 17);
      check("carry_pend_drained", pend, 0);

      // Single borrow deletes one pulse.
      pulse_req(1'b0, 1'b1, 1);
      check("borrow_pend", pend, -1);
      window(32, n_id, n_f);
      check("borrow_pulses", n_id, 15);
      check("borrow_pend_drained", pend, 0);

      // Simultaneous carry and borrow cancel.
      pulse_req(1'b1, 1'b1, 1);
      check("cancel_pend", pend, 0);
      window(32, n_id, n_f);
      check("cancel_pulses", n_id, 16);

      // Continuous carries saturate at +7, then drain one per 2 cycles.
      pulse_req(1'b1, 1'b0, 20);
      check("sat_pend", pend, 7);
      repeat (2) @(negedge clk);
      check("drain_2", pend, 6);
      repeat (12) @(negedge clk);
      check("drain_14", pend, 0);

      // Reset in the middle of a drain discards the backlog.
      pulse_req(1'b1, 1'b0, 20);
      repeat (4) @(negedge clk);
      check("middrain_pend", pend, 5);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      check("middrain_rst_pend", pend, 0);
      check("middrain_rst_idOut", idOut, 0);
      check("middrain_rst_fOut", fOut, 0);

      // Disabled: carries are lost and idOut stays low.
      repeat (10) @(negedge clk);
      enable = 1'b0;
      @(negedge clk);
      n_id = 0;
      for (int i = 0; i < 20; i++) begin
         carry = i[0];
         @(negedge clk);
         n_id += int'(idOut);
      end
      carry = 1'b0;
      check("disabled_pulses", n_id, 0);
      check("disabled_pend", pend, 0);
      enable = 1'b1;

      // Lock detector: 64 quiet pulses, then one correction.
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      repeat (140) @(negedge clk);
      check("lock_after_quiet", locked, LockEn ? 1 : 0);
      pulse_req(1'b0, 1'b1, 1);
      repeat (4) @(negedge clk);
      check("lock_after_borrow", locked, 0);
      repeat (4) @(negedge clk);

      // Randomized traffic: mixed request densities, enable gaps, rare resets.
      for (int i = 0; i < 3000; i++) begin
         int r, dense;
         dense  = ((i / 200) % 3 == 1) ? 1 : 0;
         r      = $urandom_range(0, 99);
         carry  = dense ? (r < 70) : (r < 12);
         borrow = dense ? (r >= 60 && r < 65) : (r >= 8 && r < 22);
         if ((i / 200) % 3 == 2) begin
            carry  = (r < 5);
            borrow = (r >= 30);
         end
         enable = ($urandom_range(0, 15) != 0);
         reset  = ($urandom_range(0, 599) == 0);
         @(negedge clk);
      end
      reset = 1'b0; enable = 1'b1; carry = 1'b0; borrow = 1'b0;

      // Drain to quiet and confirm the backlog empties within a bounded time.
      guard = 0;
      while (pend != 0 && guard < 64) begin
         @(negedge clk);
         guard++;
      end
      check("final_drain", pend, 0);
      repeat (4) @(negedge clk);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
